sram_like_bridge: RTL and testbench

Parametrised bridge converting one pipeline memory port (fixed-address, hold-until-done) into a variable-latency sram-like bus port (req/addr_ok/data_ok). The next-generation CPU top instantiates it twice, once for instruction fetch and once for data access, replacing the always-ready SRAM ports. It generates the pipeline stall and supports kill-on-flush. It also counts stall cycles for performance debug.

---
 rtl/cpu_bus_pkg.sv | 21 ++
 rtl/sram_like_bridge.sv | 123 ++++++++++++
 tb/tb_sram_like_bridge.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the pipeline-to-sram-like bus bridges:
// bridge FSM states, bus size encodings and the byte-enable width helper.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_like_bridge.sv
// Converts a hold-until-done pipeline memory port into a single-outstanding
// req/addr_ok/data_ok bus port, with stall generation, kill-on-flush and a stall counter.
module sram_like_bridge
    import cpu_bus_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cpu_en,
    input  logic [be_width(DW)-1:0] cpu_wen,
    input  logic [1:0]              cpu_size,
    input  logic [AW-1:0]           cpu_addr,
    input  logic [DW-1:0]           cpu_wdata,
    input  logic                    cpu_flush,
    output logic [DW-1:0]           cpu_rdata,
    output logic                    cpu_rvalid,
    output logic                    cpu_stall,
    output logic                    req,
    output logic                    wr,
    output logic [1:0]              size,
    output logic [AW-1:0]           addr,
    output logic [DW-1:0]           wdata,
    input  logic                    addr_ok,
    input  logic                    data_ok,
    input  logic [DW-1:0]           rdata,
    output logic [CNT_W-1:0]        stall_cnt,
    output bridge_state_e           dbg_state
);

    bridge_state_e    state_q, state_d;
    logic             wr_q, wr_d;
    logic [1:0]       size_q, size_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_raw;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        kill_d     = kill_q;
        req        = 1'b0;
        cpu_rvalid = 1'b0;
        stall_raw  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_en && !cpu_flush) begin
                    wr_d      = |cpu_wen;
                    size_d    = cpu_size;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wdata;
                    kill_d    = 1'b0;
                    stall_raw = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // The request cannot be withdrawn once raised; a flush only marks it killed.
                req       = 1'b1;
                stall_raw = 1'b1;
                if (cpu_flush) kill_d = 1'b1;
                if (addr_ok) state_d = ST_DATA;
            end
            ST_DATA: begin
                stall_raw = 1'b1;
                if (cpu_flush) kill_d = 1'b1;
                if (data_ok) begin
                    rdata_d = rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_rvalid = ~kill_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall is forced low while reset is held, even if the pipeline requests.
    assign cpu_stall   = stall_raw & resetn;
    assign stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, cpu_stall};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            kill_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            kill_q      <= kill_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wr        = wr_q;
    assign size      = size_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign cpu_rdata = rdata_q;
    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: a 32-bit instance for the main protocol
// cases and a 64-bit instance with a 4-bit stall counter for width and wrap cases.
module tb_sram_like_bridge;
    import cpu_bus_pkg::*;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_cnt = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance ----------------
    logic        cpu_en = 0, cpu_flush = 0, addr_ok = 0, data_ok = 0;
    logic [3:0]  cpu_wen = 0;
    logic [1:0]  cpu_size = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, brdata = 0;
    logic [31:0] cpu_rdata, addr, wdata, stall_cnt;
    logic        cpu_rvalid, cpu_stall, req, wr;
    logic [1:0]  size;
    bridge_state_e dbg_state;

    sram_like_bridge #(.AW(32), .DW(32), .CNT_W(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cpu_stall(cpu_stall), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(brdata),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // ---------------- 64-bit instance, 4-bit counter ----------------
    logic        h_en = 0, h_flush = 0, h_addr_ok = 0, h_data_ok = 0;
    logic [7:0]  h_wen = 0;
    logic [1:0]  h_csize = 0;
    logic [31:0] h_caddr = 0;
    logic [63:0] h_cwdata = 0, h_brdata = 0;
    logic [63:0] h_rdata, h_wdata;
    logic [31:0] h_addr;
    logic        h_rvalid, h_stall, h_req, h_wr;
    logic [1:0]  h_size;
    logic [3:0]  h_cnt;
    bridge_state_e h_dbg;

    sram_like_bridge #(.AW(32), .DW(64), .CNT_W(4)) u_dut64 (
        .clk(clk), .resetn(resetn), .cpu_en(h_en), .cpu_wen(h_wen),
        .cpu_size(h_csize), .cpu_addr(h_caddr), .cpu_wdata(h_cwdata),
        .cpu_flush(h_flush), .cpu_rdata(h_rdata), .cpu_rvalid(h_rvalid),
        .cpu_stall(h_stall), .req(h_req), .wr(h_wr), .size(h_size), .addr(h_addr),
        .wdata(h_wdata), .addr_ok(h_addr_ok), .data_ok(h_data_ok), .rdata(h_brdata),
        .stall_cnt(h_cnt), .dbg_state(h_dbg)
    );

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one 32-bit access ----------------
    // Cycle i=0 is IDLE with cpu_en, then aw+1 ADDR cycles, dw+1 DATA cycles, one DONE cycle.
    task automatic access32(input logic [3:0] wen, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int aw, input int dw,
                            input bit fl);
        int  n;
        bit  is_wr, in_addr, in_done;
        n     = aw + dw + 4;
        is_wr = |wen;
        if (!is_wr && !fl) exp_q.push_back({32'h0, rd});
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_addr   = (i >= 1) && (i <= aw + 1);
            in_done   = (i == n - 1);
            cpu_en    = !in_done;
            cpu_wen   = wen;
            cpu_size  = sz;
            cpu_addr  = a;
            cpu_wdata = wd;
            cpu_flush = fl && (i == 1);
            addr_ok   = (i == aw + 1);
            data_ok   = (i == aw + dw + 2);
            brdata    = data_ok ? rd : $urandom;
            #1;
            chk("stall", {63'h0, cpu_stall}, {63'h0, !in_done});
            chk("req", {63'h0, req}, {63'h0, in_addr});
            chk("rvalid", {63'h0, cpu_rvalid}, {63'h0, in_done && !fl});
            if (in_addr) begin
                chk("bus_wr", {63'h0, wr}, {63'h0, is_wr});
                chk("bus_size", {62'h0, size}, {62'h0, sz});
                chk("bus_addr", {32'h0, addr}, {32'h0, a});
                chk("bus_wdata", {32'h0, wdata}, {32'h0, wd});
            end
            if (in_done) begin
                exp_cnt = exp_cnt + 32'(n - 1);
                chk("stall_cnt", {32'h0, stall_cnt}, {32'h0, exp_cnt});
                if (!is_wr && !fl) chk("rdata", {32'h0, cpu_rdata}, exp_q.pop_front());
            end
        end
        @(negedge clk);
        cpu_en  = 0;
        addr_ok = 0;
        data_ok = 0;
        #1;
        chk("idle_after", {63'h0, cpu_stall | req}, 64'h0);
        chk("dbg_idle", {62'h0, dbg_state}, {62'h0, ST_IDLE});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n64;
        cpu_en = 1;
        h_en   = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {63'h0, cpu_stall}, 64'h0);
        chk("rst_req", {63'h0, req}, 64'h0);
        chk("rst_wr", {63'h0, wr}, 64'h0);
        chk("rst_size", {62'h0, size}, 64'h0);
        chk("rst_addr", {32'h0, addr}, 64'h0);
        chk("rst_wdata", {32'h0, wdata}, 64'h0);
        chk("rst_rdata", {32'h0, cpu_rdata}, 64'h0);
        chk("rst_rvalid", {63'h0, cpu_rvalid}, 64'h0);
        chk("rst_cnt", {32'h0, stall_cnt}, 64'h0);
        chk("rst_dbg", {62'h0, dbg_state}, {62'h0, ST_IDLE});
        chk("rst64_stall", {63'h0, h_stall}, 64'h0);
        chk("rst64_cnt", {60'h0, h_cnt}, 64'h0);
        cpu_en = 0;
        h_en   = 0;
        @(negedge clk);
        resetn = 1;

        // zero-wait read: stall_cnt reaches 3
        access32(4'b0000, SIZE_W, 32'h1FC0_0000, 32'h0, 32'h3C08_0001, 0, 0, 0);
        // halfword write with wait states on the address phase
        access32(4'b0011, SIZE_H, 32'h8000_0010, 32'h0000_BEEF, 32'hDEAD_DEAD, 2, 1, 0);
        // addr_ok after 4 extra cycles, data_ok after 3: req 5 cycles, stall 10 cycles
        access32(4'b0000, SIZE_W, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, 4, 3, 0);
        // flush while waiting for addr_ok: access completes but stays silent
        access32(4'b0000, SIZE_W, 32'h0000_0080, 32'h0, 32'h1111_2222, 2, 1, 1);
        access32(4'b0000, SIZE_B, 32'h0000_0081, 32'h0, 32'h0000_0077, 0, 0, 0);

        // request with flush in IDLE: nothing issued, no stall
        @(negedge clk);
        cpu_en    = 1;
        cpu_flush = 1;
        #1;
        chk("iflush_stall", {63'h0, cpu_stall}, 64'h0);
        chk("iflush_req", {63'h0, req}, 64'h0);
        @(negedge clk);
        cpu_en    = 0;
        cpu_flush = 0;
        #1;
        chk("iflush_req2", {63'h0, req}, 64'h0);
        chk("iflush_cnt", {32'h0, stall_cnt}, {32'h0, exp_cnt});

        // reset asserted while waiting for data
        @(negedge clk);
        cpu_en   = 1;
        cpu_wen  = 0;
        cpu_addr = 32'h0000_0100;
        @(negedge clk);
        addr_ok = 1;
        #1;
        chk("rst_mid_req", {63'h0, req}, 64'h1);
        @(negedge clk);
        addr_ok = 0;
        #1;
        chk("rst_mid_data", {62'h0, dbg_state}, {62'h0, ST_DATA});
        resetn = 0;
        #1;
        chk("rst_mid_dbg", {62'h0, dbg_state}, {62'h0, ST_IDLE});
        chk("rst_mid_reqlow", {63'h0, req}, 64'h0);
        chk("rst_mid_stall", {63'h0, cpu_stall}, 64'h0);
        chk("rst_mid_cnt", {32'h0, stall_cnt}, 64'h0);
        cpu_en = 0;
        @(negedge clk);
        resetn = 1;

        // 64-bit dword read, 7+7 wait cycles: 17 stall cycles wrap a 4-bit counter to 1
        n64 = 7 + 7 + 4;
        for (int i = 0; i < n64; i++) begin
            @(negedge clk);
            h_en      = (i != n64 - 1);
            h_csize   = SIZE_D;
            h_caddr   = 32'h0000_0100;
            h_addr_ok = (i == 8);
            h_data_ok = (i == 16);
            h_brdata  = h_data_ok ? 64'h0123_4567_89AB_CDEF : {$urandom, $urandom};
            #1;
            if (i == 1) chk("d64_addr", {32'h0, h_addr}, 64'h100);
            if (i == 1) chk("d64_size", {62'h0, h_size}, 64'h3);
            if (i == n64 - 1) begin
                chk("d64_rvalid", {63'h0, h_rvalid}, 64'h1);
                chk("d64_rdata", h_rdata, 64'h0123_4567_89AB_CDEF);
                chk("d64_cnt_wrap", {60'h0, h_cnt}, 64'h1);
            end
        end
        @(negedge clk);
        h_en      = 0;
        h_data_ok = 0;
        h_addr_ok = 0;
        #1;
        chk("d64_stall_low", {63'h0, h_stall}, 64'h0);
        chk("exp_q_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
